pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode width; values below occupy the low 6 bits, upper bits SHALL be zero for a match.
REQ-002 Parameter ALUOP_W, default 4, ALU operation field width.
REQ-003 Parameter REG_W, default 3, register index width.
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 instr_valid  in  1  decode stage holds a valid word.
REQ-008 opcode  in  OPCODE_W  opcode of the word in decode.
REQ-009 rs1, rs2  in  REG_W each  source register indices of the word in decode.
REQ-010 ex_mem_read, ex_rd  in  1 / REG_W  EX-stage instruction is a load, and its destination register.
REQ-011 flush  in  1  kill the instruction in decode.
REQ-012 ex_sig  out  ALUOP_W+2  registered {aluop, alu_en, sham_sel}.
REQ-013 mem_sig  out  4  registered {memRead, memWrite, memAddress, memData}.
REQ-014 wb_sig  out  3  registered {regWrite, wbSel[1:0]}; wbSel 00 MEM, 01 ALU, 10 IMM.
REQ-015 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-016 illegal  out  1  registered; previous decoded word had an undefined opcode.
REQ-017 stall_count  out  CNT_W  number of hazard stall cycles.

Function
REQ-018 Opcodes: NOP 000101, NOT 000100, ADD 000011, LDD 000001, STD 000010, LDM 000110.
REQ-019 Encodings {ex|mem|wb}: NOP {aluop 0, en 1, sham 0 | 0000 | 011}; NOT {1,1,0 | 0000 | 101}; ADD {2,1,0 | 0000 | 101}; LDD {0,0,0 | 1000 | 100}; STD {0,0,0 | 0110 | 011}; LDM {0,0,0 | 0000 | 110}.
REQ-020 Bubble = NOP encoding; unused fields drive 0, never X.
REQ-021 Outputs are registered: signals for the word in decode at cycle N appear at cycle N+1.
REQ-022 States: RUN, IMM.
REQ-023 RUN, LDM decoded: emit bubble, go to IMM; in IMM the decode word is the immediate: emit LDM encoding, return to RUN; no hazard check, no opcode decode in IMM.
REQ-024 Source usage: NOT rs1; ADD rs1,rs2; LDD rs1; STD rs1,rs2; NOP and LDM none.
REQ-025 Hazard (RUN only): instr_valid & ex_mem_read & (ex_rd equals a used source) -> stall=1, emit bubble, state unchanged.
REQ-026 instr_valid=0 -> emit bubble, stall=0, state unchanged.
REQ-027 Priority: flush > hazard > decode; flush emits bubble, stall=0, forces RUN (aborts pending LDM).
REQ-028 Undefined opcode in RUN: emit bubble, illegal=1 next cycle; illegal=0 otherwise.
REQ-029 stall_count increments on each stall=1 cycle and saturates at all-ones.

Reset
REQ-030 rst_n low: immediately state RUN, ex_sig/mem_sig/wb_sig = bubble, illegal=0, stall_count=0.
REQ-031 Reset mid-LDM discards the pending immediate; stall follows inputs combinationally with state RUN.

Configuration
REQ-032 Macro CU_HAZARD_DETECT_EN defined: REQ-025 and REQ-029 active.
REQ-033 Macro undefined: stall tied 0, no hazard bubbles, stall_count tied 0.

Verification
REQ-034 Reset release, ADD valid, rs1=1 rs2=2, no load in EX -> next cycle ex_sig aluop 2 en 1, wb_sig 101, stall 0.
REQ-035 LDD in EX (ex_mem_read=1, ex_rd=3), ADD in decode rs2=3 -> stall=1, bubble next cycle, stall_count 0->1; macro off -> stall 0, ADD encoding emitted.
REQ-036 LDM then immediate word -> outputs bubble then wb_sig 110 mem_sig 0000; immediate opcode matching ADD is not decoded.
REQ-037 LDM then flush in IMM -> bubble, state RUN; next ADD decoded normally.
REQ-038 Opcode 111111 -> bubble and illegal=1 next cycle, illegal=0 after a legal NOT.
REQ-039 rst_n low while in IMM with outputs non-bubble -> outputs bubble without clock edge; stall_count forced to 0 (after CNT_W=2 saturation at 3).

Source files
------------

// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - decode-stage control bus between pipeline and pipe_control_unit
//
// Groups the decode-stage inputs and the registered control outputs of
// pipe_control_unit. The master drives the decode word, the slave (the
// control unit) returns the stage control words.
//   instr_valid, opcode, rs1, rs2 : word currently in decode
//   ex_mem_read, ex_rd            : EX-stage load indication and destination
//   flush                         : kill the word in decode
//   ex_sig, mem_sig, wb_sig       : registered stage control words
//   stall                         : combinational hold of PC and IF/ID
//   illegal                       : previous decoded word had an undefined opcode
//   stall_count                   : saturating count of hazard stall cycles
interface pipe_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 16
);
    logic                 instr_valid;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic                 ex_mem_read;
    logic [REG_W-1:0]     ex_rd;
    logic                 flush;
    logic [ALUOP_W+1:0]   ex_sig;
    logic [3:0]           mem_sig;
    logic [2:0]           wb_sig;
    logic                 stall;
    logic                 illegal;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        output instr_valid, opcode, rs1, rs2, ex_mem_read, ex_rd, flush,
        input  ex_sig, mem_sig, wb_sig, stall, illegal, stall_count
    );

    modport slave (
        input  instr_valid, opcode, rs1, rs2, ex_mem_read, ex_rd, flush,
        output ex_sig, mem_sig, wb_sig, stall, illegal, stall_count
    );
endinterface

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - decode control unit with load-use hazard stall and two-word LDM
//
// Decodes the word in decode into registered EX/MEM/WB control words.
// LDM is a two-word instruction: the first word emits a bubble and the
// next valid word (the immediate) emits the LDM control word without decode.
// Optional load-use hazard detection is enabled by the macro
// CU_HAZARD_DETECT_EN; without it stall and stall_count are tied to 0.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_control_unit_if slave modport (decode inputs, control outputs)
module pipe_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_control_unit_if.slave bus
);
    typedef enum logic {S_RUN, S_IMM} state_t;

    // Full-width constants so that any set upper opcode bit fails the match.
    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_LDD = OPCODE_W'(6'b000001);
    localparam logic [OPCODE_W-1:0] OP_STD = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_LDM = OPCODE_W'(6'b000110);

    state_t state, state_nxt;

    logic is_nop, is_not, is_add, is_ldd, is_std, is_ldm;
    logic use_rs1, use_rs2;
    logic hazard;

    logic [ALUOP_W-1:0] nx_aluop;
    logic               nx_en;
    logic               nx_sham;
    logic [3:0]         nx_mem;
    logic [2:0]         nx_wb;
    logic               nx_illegal;

    logic [ALUOP_W+1:0] ex_q;
    logic [3:0]         mem_q;
    logic [2:0]         wb_q;
    logic               illegal_q;

    assign is_nop = (bus.opcode == OP_NOP);
    assign is_not = (bus.opcode == OP_NOT);
    assign is_add = (bus.opcode == OP_ADD);
    assign is_ldd = (bus.opcode == OP_LDD);
    assign is_std = (bus.opcode == OP_STD);
    assign is_ldm = (bus.opcode == OP_LDM);

    assign use_rs1 = is_not | is_add | is_ldd | is_std;
    assign use_rs2 = is_add | is_std;

`ifdef CU_HAZARD_DETECT_EN
    // Load-use hazard is only meaningful for a decoded word, so the immediate
    // half of LDM and a flushed word never stall.
    assign hazard = (state == S_RUN) && !bus.flush && bus.instr_valid && bus.ex_mem_read
                    && ((use_rs1 && (bus.ex_rd == bus.rs1)) || (use_rs2 && (bus.ex_rd == bus.rs2)));
`else
    assign hazard = 1'b0;
`endif

    assign bus.stall = hazard;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: flush aborts a pending immediate; an invalid or
    // stalled cycle leaves the state untouched.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_RUN;
        end else if (bus.instr_valid && !hazard) begin
            if (state == S_IMM) begin
                state_nxt = S_RUN;
            end else if (is_ldm) begin
                state_nxt = S_IMM;
            end
        end
    end

    // Output logic: control word for the next cycle, defaulting to the bubble
    // (NOP encoding) for flush, invalid, stalled, LDM-first and undefined words.
    always_comb begin
        nx_aluop   = '0;
        nx_en      = 1'b1;
        nx_sham    = 1'b0;
        nx_mem     = 4'b0000;
        nx_wb      = 3'b011;
        nx_illegal = 1'b0;
        if (!bus.flush && bus.instr_valid && !hazard) begin
            if (state == S_IMM) begin
                nx_en = 1'b0;
                nx_wb = 3'b110;
            end else if (is_not) begin
                nx_aluop = ALUOP_W'(1);
                nx_wb    = 3'b101;
            end else if (is_add) begin
                nx_aluop = ALUOP_W'(2);
                nx_wb    = 3'b101;
            end else if (is_ldd) begin
                nx_en  = 1'b0;
                nx_mem = 4'b1000;
                nx_wb  = 3'b100;
            end else if (is_std) begin
                nx_en  = 1'b0;
                nx_mem = 4'b0110;
                nx_wb  = 3'b011;
            end else if (!is_nop && !is_ldm) begin
                nx_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= {{ALUOP_W{1'b0}}, 1'b1, 1'b0};
            mem_q     <= 4'b0000;
            wb_q      <= 3'b011;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= {nx_aluop, nx_en, nx_sham};
            mem_q     <= nx_mem;
            wb_q      <= nx_wb;
            illegal_q <= nx_illegal;
        end
    end

    assign bus.ex_sig  = ex_q;
    assign bus.mem_sig = mem_q;
    assign bus.wb_sig  = wb_q;
    assign bus.illegal = illegal_q;

`ifdef CU_HAZARD_DETECT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed self-checking bench for pipe_control_unit
module tb_pipe_control_unit;
    localparam int OW = 6;
    localparam int AW = 4;
    localparam int RW = 3;
    localparam int CW = 2;

`ifdef CU_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [5:0] OP_NOP = 6'b000101;
    localparam logic [5:0] OP_NOT = 6'b000100;
    localparam logic [5:0] OP_ADD = 6'b000011;
    localparam logic [5:0] OP_LDD = 6'b000001;
    localparam logic [5:0] OP_STD = 6'b000010;
    localparam logic [5:0] OP_LDM = 6'b000110;

    localparam logic [5:0] EX_NOP = 6'b000010;
    localparam logic [5:0] EX_NOT = 6'b000110;
    localparam logic [5:0] EX_ADD = 6'b001010;
    localparam logic [5:0] EX_OFF = 6'b000000;
    localparam logic [2:0] WB_NOP = 3'b011;
    localparam logic [2:0] WB_ALU = 3'b101;
    localparam logic [2:0] WB_LDD = 3'b100;
    localparam logic [2:0] WB_LDM = 3'b110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipe_control_unit_if #(.OPCODE_W(OW), .ALUOP_W(AW), .REG_W(RW), .CNT_W(CW)) bus ();

    pipe_control_unit #(.OPCODE_W(OW), .ALUOP_W(AW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [5:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic lr, input logic [2:0] rd, input logic fl);
        bus.instr_valid = v;
        bus.opcode      = op;
        bus.rs1         = a;
        bus.rs2         = b;
        bus.ex_mem_read = lr;
        bus.ex_rd       = rd;
        bus.flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b0, OP_NOP, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        #12;
        check("rst_ex", 32'(bus.ex_sig), 32'(EX_NOP));
        check("rst_mem", 32'(bus.mem_sig), 32'h0);
        check("rst_wb", 32'(bus.wb_sig), 32'(WB_NOP));
        check("rst_illegal", 32'(bus.illegal), 32'h0);
        check("rst_cnt", 32'(bus.stall_count), 32'h0);
        rst_n = 1'b1;

        // ADD, no load in EX
        apply(1'b1, OP_ADD, 3'd1, 3'd2, 1'b0, 3'd0, 1'b0);
        #1 check("add_stall", 32'(bus.stall), 32'h0);
        tick();
        check("add_ex", 32'(bus.ex_sig), 32'(EX_ADD));
        check("add_mem", 32'(bus.mem_sig), 32'h0);
        check("add_wb", 32'(bus.wb_sig), 32'(WB_ALU));

        // load-use hazard on rs2
        apply(1'b1, OP_ADD, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0);
        #1 check("haz_stall", 32'(bus.stall), 32'(HZ));
        tick();
        check("haz_ex", 32'(bus.ex_sig), 32'(HZ ? EX_NOP : EX_ADD));
        check("haz_wb", 32'(bus.wb_sig), 32'(HZ ? WB_NOP : WB_ALU));
        check("haz_cnt", 32'(bus.stall_count), HZ ? 32'd1 : 32'd0);

        // LDM then immediate that looks like a hazarding ADD
        apply(1'b1, OP_LDM, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        check("ldm1_ex", 32'(bus.ex_sig), 32'(EX_NOP));
        check("ldm1_wb", 32'(bus.wb_sig), 32'(WB_NOP));
        apply(1'b1, OP_ADD, 3'd2, 3'd2, 1'b1, 3'd2, 1'b0);
        #1 check("imm_stall", 32'(bus.stall), 32'h0);
        tick();
        check("imm_ex", 32'(bus.ex_sig), 32'(EX_OFF));
        check("imm_mem", 32'(bus.mem_sig), 32'h0);
        check("imm_wb", 32'(bus.wb_sig), 32'(WB_LDM));

        // LDM then flush in IMM, then ADD decodes normally
        apply(1'b1, OP_LDM, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        apply(1'b1, OP_ADD, 3'd1, 3'd2, 1'b0, 3'd0, 1'b1);
        tick();
        check("flush_ex", 32'(bus.ex_sig), 32'(EX_NOP));
        check("flush_wb", 32'(bus.wb_sig), 32'(WB_NOP));
        apply(1'b1, OP_ADD, 3'd1, 3'd2, 1'b0, 3'd0, 1'b0);
        tick();
        check("postflush_ex", 32'(bus.ex_sig), 32'(EX_ADD));
        check("postflush_wb", 32'(bus.wb_sig), 32'(WB_ALU));

        // undefined opcode then a legal NOT
        apply(1'b1, 6'b111111, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        check("ill_flag", 32'(bus.illegal), 32'h1);
        check("ill_ex", 32'(bus.ex_sig), 32'(EX_NOP));
        apply(1'b1, OP_NOT, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        check("not_illegal", 32'(bus.illegal), 32'h0);
        check("not_ex", 32'(bus.ex_sig), 32'(EX_NOT));
        check("not_wb", 32'(bus.wb_sig), 32'(WB_ALU));

        // LDD and STD encodings
        apply(1'b1, OP_LDD, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        check("ldd_ex", 32'(bus.ex_sig), 32'(EX_OFF));
        check("ldd_mem", 32'(bus.mem_sig), 32'h8);
        check("ldd_wb", 32'(bus.wb_sig), 32'(WB_LDD));
        apply(1'b1, OP_STD, 3'd1, 3'd2, 1'b0, 3'd0, 1'b0);
        tick();
        check("std_mem", 32'(bus.mem_sig), 32'h6);
        check("std_wb", 32'(bus.wb_sig), 32'(WB_NOP));

        // invalid word never stalls; NOT ignores rs2
        apply(1'b0, OP_ADD, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0);
        #1 check("inv_stall", 32'(bus.stall), 32'h0);
        tick();
        check("inv_wb", 32'(bus.wb_sig), 32'(WB_NOP));
        apply(1'b1, OP_NOT, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0);
        #1 check("not_rs2_stall", 32'(bus.stall), 32'h0);
        tick();
        check("not_rs2_ex", 32'(bus.ex_sig), 32'(EX_NOT));

        // three more stalls: counter 1 -> 2 -> 3 -> stays 3
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, OP_STD, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0);
            tick();
        end
        check("sat_cnt", 32'(bus.stall_count), HZ ? 32'd3 : 32'd0);

        // reset with non-bubble outputs (LDM immediate just emitted)
        apply(1'b1, OP_LDM, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        apply(1'b1, OP_NOP, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        check("pre_rst_wb", 32'(bus.wb_sig), 32'(WB_LDM));
        rst_n = 1'b0;
        #1;
        check("async_rst_ex", 32'(bus.ex_sig), 32'(EX_NOP));
        check("async_rst_wb", 32'(bus.wb_sig), 32'(WB_NOP));
        check("async_rst_cnt", 32'(bus.stall_count), 32'h0);
        #1 rst_n = 1'b1;

        // reset while in IMM: pending immediate dropped, stall seen in RUN
        apply(1'b1, OP_LDM, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        apply(1'b1, OP_ADD, 3'd5, 3'd0, 1'b1, 3'd5, 1'b0);
        #1 check("in_imm_stall", 32'(bus.stall), 32'h0);
        rst_n = 1'b0;
        #1 check("rst_imm_stall", 32'(bus.stall), 32'(HZ));
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_ex", 32'(bus.ex_sig), 32'(HZ ? EX_NOP : EX_ADD));
        check("post_rst_wb", 32'(bus.wb_sig), 32'(HZ ? WB_NOP : WB_ALU));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
